apb_arbiter2: RTL

Two-master APB arbiter sharing one downstream APB slave port, e.g. the delayer/peripheral crossbar input, between the CPU LSU and a DMA engine. Each master runs a normal APB transfer upstream. The arbiter grants one master, replays its SETUP/ACCESS phases downstream, and routes the completion back only to that master. Arbitration is round-robin; fixed priority is available as an option.

---
 rtl/apb_arbiter2.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/apb_arbiter2.sv
//------------------------------------------------------------------------------
// Module  : apb_arbiter2
// Brief   : Two-master APB arbiter, round-robin or fixed priority, one slave port.
//           Optional ACCESS-phase timeout enabled by defining APB_ARB_TIMEOUT_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module apb_arbiter2 #(
    parameter bit          FIXED_PRIO = 1'b0,
    parameter logic [15:0] TIMEOUT    = 16'd255
) (
    input  logic        clock,
    input  logic        reset,

    input  logic [31:0] m0_paddr,
    input  logic        m0_psel,
    input  logic        m0_penable,
    input  logic [2:0]  m0_pprot,
    input  logic        m0_pwrite,
    input  logic [31:0] m0_pwdata,
    input  logic [3:0]  m0_pstrb,
    output logic        m0_pready,
    output logic [31:0] m0_prdata,
    output logic        m0_pslverr,

    input  logic [31:0] m1_paddr,
    input  logic        m1_psel,
    input  logic        m1_penable,
    input  logic [2:0]  m1_pprot,
    input  logic        m1_pwrite,
    input  logic [31:0] m1_pwdata,
    input  logic [3:0]  m1_pstrb,
    output logic        m1_pready,
    output logic [31:0] m1_prdata,
    output logic        m1_pslverr,

    output logic [31:0] out_paddr,
    output logic [2:0]  out_pprot,
    output logic        out_pwrite,
    output logic [31:0] out_pwdata,
    output logic [3:0]  out_pstrb,
    output logic        out_psel,
    output logic        out_penable,
    input  logic        out_pready,
    input  logic [31:0] out_prdata,
    input  logic        out_pslverr
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t r_state;
    logic   r_grant;
    logic   r_last;

    logic   w_next_grant;
    logic   w_done_ok;
    logic   w_tmo;
    logic   w_done;

    // Upstream penable carries no information the arbiter needs; psel level alone drives sequencing.
`ifdef APB_ARB_TIMEOUT_EN
    logic        w_unused;
    assign w_unused = m0_penable ^ m1_penable;
`else
    logic        w_unused;
    assign w_unused = m0_penable ^ m1_penable ^ (^TIMEOUT);
`endif

    always_comb begin
        w_next_grant = 1'b0;
        if (m0_psel && m1_psel)
            w_next_grant = FIXED_PRIO ? 1'b0 : ~r_last;
        else if (m1_psel)
            w_next_grant = 1'b1;
    end

    assign w_done_ok = (r_state == S_ACCESS) && out_pready;

`ifdef APB_ARB_TIMEOUT_EN
    logic [15:0] r_tmo_cnt;

    // A real completion in the same cycle as the limit takes precedence.
    assign w_tmo = (r_state == S_ACCESS) && !out_pready && (r_tmo_cnt == TIMEOUT);

    always_ff @(posedge clock) begin
        if (reset)
            r_tmo_cnt <= 16'd0;
        else if (r_state == S_SETUP)
            r_tmo_cnt <= 16'd0;
        else if (r_state == S_ACCESS && !out_pready && !w_tmo)
            r_tmo_cnt <= r_tmo_cnt + 16'd1;
    end
`else
    assign w_tmo = 1'b0;
`endif

    assign w_done = w_done_ok || w_tmo;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_grant <= 1'b0;
            r_last  <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (m0_psel || m1_psel) begin
                        r_grant <= w_next_grant;
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: r_state <= S_ACCESS;
                S_ACCESS: begin
                    if (w_done) begin
                        r_last  <= r_grant;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign out_psel    = (r_state != S_IDLE);
    assign out_penable = (r_state == S_ACCESS);

    assign out_paddr  = r_grant ? m1_paddr  : m0_paddr;
    assign out_pprot  = r_grant ? m1_pprot  : m0_pprot;
    assign out_pwrite = r_grant ? m1_pwrite : m0_pwrite;
    assign out_pwdata = r_grant ? m1_pwdata : m0_pwdata;
    assign out_pstrb  = r_grant ? m1_pstrb  : m0_pstrb;

    // Timeout completions report an error with zeroed read data.
    assign m0_pready  = w_done && !r_grant;
    assign m0_prdata  = (w_done_ok && !r_grant) ? out_prdata : 32'd0;
    assign m0_pslverr = !r_grant && (w_done_ok ? out_pslverr : w_tmo);

    assign m1_pready  = w_done && r_grant;
    assign m1_prdata  = (w_done_ok && r_grant) ? out_prdata : 32'd0;
    assign m1_pslverr = r_grant && (w_done_ok ? out_pslverr : w_tmo);

endmodule

`default_nettype wire
